// File: rtl/upsampler_pkg.sv
// Shared types and constants for the 2x nearest-neighbour upsampler.
// Defaults match the full-size pyramid stage (320x240, 8-bit pixels).
package upsampler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_REPLAY
  } state_e;

  localparam int unsigned IMG_W_DEF = 320;
  localparam int unsigned IMG_H_DEF = 240;
  localparam int unsigned DW_DEF    = 8;

  // Counter width that never collapses to zero bits for degenerate sizes.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned COL_W = cnt_w(IMG_W_DEF);
  localparam int unsigned ROW_W = cnt_w(IMG_H_DEF);

endpackage

// File: rtl/gauss_upsampler_if.sv
// FIFO-side and output-stream signals of the upsampler.
// sof/eol exist only when GAUSS_UPSAMPLER_SYNC_EN is defined.
interface gauss_upsampler_if #(
  parameter int unsigned DW = 8
);
  logic [DW-1:0] din;
  logic          din_valid;
  logic          empty;
  logic          rd_en;
  logic [DW-1:0] dout;
  logic          out_valid;
  logic          out_ready;
  logic          frame_done;
`ifdef GAUSS_UPSAMPLER_SYNC_EN
  logic          sof;
  logic          eol;

  modport slave (
    input  din, din_valid, empty, out_ready,
    output rd_en, dout, out_valid, frame_done, sof, eol
  );

  modport master (
    output din, din_valid, empty, out_ready,
    input  rd_en, dout, out_valid, frame_done, sof, eol
  );
`else
  modport slave (
    input  din, din_valid, empty, out_ready,
    output rd_en, dout, out_valid, frame_done
  );

  modport master (
    output din, din_valid, empty, out_ready,
    input  rd_en, dout, out_valid, frame_done
  );
`endif
endinterface

// File: rtl/upsample_line_buffer.sv
// Single-port line RAM holding one input row for the replay pass.
// Synchronous read with a registered output; write takes priority.
module upsample_line_buffer
  import upsampler_pkg::*;
#(
  parameter int unsigned Depth = IMG_W_DEF,
  parameter int unsigned Width = DW_DEF,
  localparam int unsigned AddrW = cnt_w(Depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AddrW-1:0] addr_i,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re_i && !we_i) rdata_d = mem_q[addr_i];
  end

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/gauss_upsampler.sv
// 2x nearest-neighbour upsampler fed from the Gaussian stage FIFO.
// Optional sof/eol outputs are enabled by GAUSS_UPSAMPLER_SYNC_EN.
module gauss_upsampler
  import upsampler_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF,
  parameter int unsigned DW    = DW_DEF
) (
  input logic               clk,
  input logic               rst,
  gauss_upsampler_if.slave  bus
);

  localparam int unsigned ColW = cnt_w(IMG_W);
  localparam int unsigned RowW = cnt_w(IMG_H);

  typedef logic [ColW-1:0] col_t;
  typedef logic [RowW-1:0] row_t;

  localparam col_t ColLast = col_t'(IMG_W - 1);
  localparam row_t RowLast = row_t'(IMG_H - 1);

  state_e        st_q, st_d;
  col_t          col_q, col_d;
  row_t          row_q, row_d;
  logic          dup_q, dup_d;
  logic          hold_v_q, hold_v_d;
  logic [DW-1:0] hold_data_q, hold_data_d;
  logic          infl_q, infl_d;
  logic          frame_done_q, frame_done_d;

  logic          xfer, fetch_ok, rd_en, lb_re, cap_fifo, cap_lb;
  logic [DW-1:0] lb_rdata;

  // Fetches wait for an empty hold slot, no outstanding fetch and a ready sink.
  assign xfer     = hold_v_q & bus.out_ready;
  assign fetch_ok = !hold_v_q && !infl_q && bus.out_ready;
  assign rd_en    = (st_q == ST_FILL) && fetch_ok && !bus.empty;
  assign lb_re    = (st_q == ST_REPLAY) && fetch_ok;
  assign cap_fifo = (st_q == ST_FILL) && infl_q && bus.din_valid;
  assign cap_lb   = (st_q == ST_REPLAY) && infl_q;

  upsample_line_buffer #(
    .Depth (IMG_W),
    .Width (DW)
  ) u_line_buffer (
    .clk     (clk),
    .rst     (rst),
    .addr_i  (col_q),
    .we_i    (cap_fifo),
    .re_i    (lb_re),
    .wdata_i (bus.din),
    .rdata_o (lb_rdata)
  );

  always_comb begin
    st_d         = st_q;
    col_d        = col_q;
    row_d        = row_q;
    dup_d        = dup_q;
    hold_v_d     = hold_v_q;
    hold_data_d  = hold_data_q;
    infl_d       = infl_q;
    frame_done_d = 1'b0;

    if (st_q == ST_IDLE && !bus.empty) st_d = ST_FILL;

    if (rd_en || lb_re) infl_d = 1'b1;

    if (cap_fifo) begin
      hold_data_d = bus.din;
      hold_v_d    = 1'b1;
      infl_d      = 1'b0;
    end else if (cap_lb) begin
      hold_data_d = lb_rdata;
      hold_v_d    = 1'b1;
      infl_d      = 1'b0;
    end

    // Second copy of a pixel retires it; the last pixel of a row ends the pass.
    if (xfer) begin
      dup_d = ~dup_q;
      if (dup_q) begin
        hold_v_d = 1'b0;
        if (col_q == ColLast) begin
          col_d = '0;
          if (st_q == ST_FILL) begin
            st_d = ST_REPLAY;
          end else if (row_q == RowLast) begin
            st_d         = ST_IDLE;
            row_d        = '0;
            frame_done_d = 1'b1;
          end else begin
            st_d  = ST_FILL;
            row_d = row_q + row_t'(1);
          end
        end else begin
          col_d = col_q + col_t'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q         <= ST_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      dup_q        <= 1'b0;
      hold_v_q     <= 1'b0;
      hold_data_q  <= '0;
      infl_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      st_q         <= st_d;
      col_q        <= col_d;
      row_q        <= row_d;
      dup_q        <= dup_d;
      hold_v_q     <= hold_v_d;
      hold_data_q  <= hold_data_d;
      infl_q       <= infl_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.rd_en      = rd_en;
  assign bus.dout       = hold_data_q;
  assign bus.out_valid  = hold_v_q;
  assign bus.frame_done = frame_done_q;

`ifdef GAUSS_UPSAMPLER_SYNC_EN
  // FILL is always the first pass of an input row.
  assign bus.sof = hold_v_q && (st_q == ST_FILL) && (row_q == '0) && (col_q == '0) && !dup_q;
  assign bus.eol = hold_v_q && (col_q == ColLast) && dup_q;
`endif

endmodule
